// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

    // 1 when data plus parity bit hold an odd number of ones (a good frame).
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchroniser, debounce and falling-edge strobe for kb_clk; kb_data gets the
// same synchroniser plus a delay matching the debounce latency.
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic kb_clk,
    input  logic kb_data,
    output logic clk_filt,
    output logic fall,
    output logic data_aligned
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [FILTER_LEN-1:0]  data_dly;
    logic [CW-1:0]          cnt;
    logic                   clk_s;

    assign clk_s        = clk_sync[SYNC_STAGES-1];
    assign data_aligned = data_dly[FILTER_LEN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            data_dly  <= '1;
            cnt       <= '0;
            clk_filt  <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sync[0]  <= kb_clk;
            data_sync[0] <= kb_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            data_dly[0] <= data_sync[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++)
                data_dly[i] <= data_dly[i-1];

            // Any sample agreeing with the filtered level restarts the run.
            fall <= 1'b0;
            if (clk_s == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt      <= '0;
                clk_filt <= clk_s;
                fall     <= clk_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: start, 8 data LSB first, odd parity, stop.
// Parity checking is built only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] scan_code,
    output logic       valid_code,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    ps2_state_e               state;
    logic [BW-1:0]            bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     par_bit;
    logic [TW-1:0]            to_cnt;
    logic                     clk_filt;
    logic                     fall;
    logic                     data_s;

    ps2_clk_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk         (clk),
        .rst         (rst),
        .kb_clk      (kb_clk),
        .kb_data     (kb_data),
        .clk_filt    (clk_filt),
        .fall        (fall),
        .data_aligned(data_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            scan_code  <= '0;
            valid_code <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid_code <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (data_s == PS2_START_BIT) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1))
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (data_s != PS2_STOP_BIT) begin
                            frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                        end else if (!odd_parity(shreg, par_bit)) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            scan_code  <= shreg;
                            valid_code <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Truncated frame: drop partial byte, keep last good scan_code.
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    state     <= ST_IDLE;
                    to_cnt    <= '0;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: table vectors, corner sequences and
// random frames checked against a frame-level reference model.
module tb_ps2_frame_rx;

    localparam int TO      = 300;
    localparam int HALF    = 30;
    localparam int STRETCH = TO - HALF - 30;
    localparam int EV_VALID = 1;
    localparam int EV_FERR  = 2;
    localparam int EV_PERR  = 3;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         kind;
        logic [7:0] code;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic [7:0] scan_code;
    logic       valid_code, frame_err, parity_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_multi = 0;
    int         n_unstable = 0;
    ev_t        evq[$];
    logic [7:0] model_last = 8'h00;
    logic [7:0] prev_code = 8'h00;
    vec_t       tbl[9];

    ps2_frame_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kb_clk    (kb_clk),
        .kb_data   (kb_data),
        .scan_code (scan_code),
        .valid_code(valid_code),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Output monitor: records every pulse as an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(valid_code) + int'(frame_err) + int'(parity_err) > 1) n_multi++;
            if (valid_code) evq.push_back('{EV_VALID, scan_code});
            if (frame_err)  evq.push_back('{EV_FERR, scan_code});
            if (parity_err) evq.push_back('{EV_PERR, scan_code});
            if (!valid_code && scan_code !== prev_code) n_unstable++;
        end
        prev_code = scan_code;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t model(input logic [7:0] d, input logic p, input logic s);
        ev_t e;
        e.code = d;
        if (!s)                                         e.kind = EV_FERR;
        else if (PAR_EN && ($countones({d, p}) % 2 == 0)) e.kind = EV_PERR;
        else                                            e.kind = EV_VALID;
        return e;
    endfunction

    task automatic send_bit(input logic b, input int hi, input bit glitch);
        kb_data = b;
        if (glitch) begin
            repeat (8) @(negedge clk);
            kb_clk = 1'b0;
            repeat (3) @(negedge clk);
            kb_clk = 1'b1;
            repeat (hi - 11) @(negedge clk);
        end else begin
            repeat (hi) @(negedge clk);
        end
        kb_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        kb_clk = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input logic p, input logic s,
                                input int nbits, input bit glitch, input int stretch_at);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], (i == stretch_at) ? STRETCH : HALF, glitch);
        kb_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_partial(d, p, s, 11, 1'b0, -1);
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [7:0] code);
        ev_t e;
        int  budget;
        budget = 0;
        while (evq.size() == 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk({name, "_present"}, evq.size() > 0, 1'b1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({name, "_kind"}, e.kind, kind);
            if (kind == EV_VALID) chk({name, "_code"}, e.code, code);
        end
        if (kind == EV_VALID) model_last = code;
    endtask

    task automatic chk_quiet(input string name);
        repeat (5) @(negedge clk);
        chk({name, "_no_extra"}, evq.size(), 0);
        chk({name, "_scan"}, scan_code, model_last);
        evq.delete();
    endtask

    initial begin
        int  cyc;
        bit  seen;
        ev_t e;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, EV_VALID, 8'h1C};
        tbl[1] = '{8'hF0, 1'b1, 1'b1, EV_VALID, 8'hF0};
        tbl[2] = '{8'h1C, 1'b1, 1'b1, PAR_EN ? EV_PERR : EV_VALID, 8'h1C};
        tbl[3] = '{8'h29, 1'b0, 1'b0, EV_FERR, 8'h00};
        tbl[4] = '{8'h5A, 1'b1, 1'b1, EV_VALID, 8'h5A};
        tbl[5] = '{8'h00, 1'b1, 1'b1, EV_VALID, 8'h00};
        tbl[6] = '{8'h80, 1'b1, 1'b1, PAR_EN ? EV_PERR : EV_VALID, 8'h80};
        tbl[7] = '{8'h01, 1'b0, 1'b1, EV_VALID, 8'h01};
        tbl[8] = '{8'hFF, 1'b1, 1'b1, EV_VALID, 8'hFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_outs", {valid_code, frame_err, parity_err}, 3'b000);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_quiet("post_rst");

        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            expect_ev($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].code);
            chk_quiet($sformatf("tbl%0d", i));
        end

        // Back-to-back frames with no idle gap
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_ev("b2b_first", EV_VALID, 8'hF0);
        expect_ev("b2b_second", EV_VALID, 8'h1C);
        chk_quiet("b2b");

        // Short glitches and a spurious fall while idle, then glitches inside a frame
        for (int g = 0; g < 3; g++) begin
            kb_clk = 1'b0;
            repeat (3) @(negedge clk);
            kb_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        kb_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        kb_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        chk_quiet("idle_glitch");
        send_partial(8'h29, 1'b0, 1'b1, 11, 1'b1, -1);
        expect_ev("glitch_frame", EV_VALID, 8'h29);
        chk_quiet("glitch_frame");

        // A long (but legal) bit period must not time out
        send_partial(8'h5A, 1'b1, 1'b1, 11, 1'b0, 4);
        expect_ev("slow_bit", EV_VALID, 8'h5A);
        chk_quiet("slow_bit");

        // Truncated frame: start + 4 data bits, then silence
        send_partial(8'h29, 1'b0, 1'b1, 5, 1'b0, -1);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 2 * TO) begin
            @(negedge clk);
            cyc++;
            if (evq.size() > 0) seen = 1'b1;
        end
        chk("timeout_seen", seen, 1'b1);
        chk("timeout_window", (cyc >= TO - HALF) && (cyc <= TO - HALF + 25), 1'b1);
        expect_ev("timeout", EV_FERR, 8'h00);
        chk_quiet("timeout");
        send_frame(8'h29, 1'b0, 1'b1);
        expect_ev("after_timeout", EV_VALID, 8'h29);
        chk_quiet("after_timeout");

        // Reset mid-frame after 5 bits
        send_partial(8'hA5, 1'b1, 1'b1, 5, 1'b0, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_scan", scan_code, 8'h00);
        chk("midrst_outs", {valid_code, frame_err, parity_err}, 3'b000);
        rst = 1'b0;
        model_last = 8'h00;
        evq.delete();
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        expect_ev("after_rst", EV_VALID, 8'h5A);
        chk_quiet("after_rst");

        // Random frames against the reference model
        for (int r = 0; r < 30; r++) begin
            logic [7:0] d;
            logic       p, s;
            d = 8'($urandom);
            p = ~^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 7) != 0);
            e = model(d, p, s);
            send_partial(d, p, s, 11, 1'($urandom_range(0, 1)), -1);
            expect_ev($sformatf("rnd%0d", r), e.kind, e.code);
            chk_quiet($sformatf("rnd%0d", r));
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        chk("single_pulse", n_multi, 0);
        chk("scan_stable", n_unstable, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
